// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 UART transmitter: register decode, circular TX FIFO, bit serializer; reads return 1 cycle
// after the address is sampled. No backpressure: a push to a full FIFO drops the byte and sets sticky overflow.
package mmio_uart_pkg;
    localparam int xlen = 32;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [xlen-1:0] addr;
        logic            enable;
        logic [xlen-1:0] value;
        mem_width_t      width;
    } mem_write_control_t;
endpackage

module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] base_addr    = 32'h0003_0000,
    parameter int          fifo_depth   = 8,
    parameter logic [15:0] reset_clkdiv = 16'd433
) (
    input  logic               clock,
    input  logic               reset,
    input  mem_write_control_t io_control,
    output logic [xlen-1:0]    io_r_data,
    output logic               tx,
    output logic               tx_busy
);
    localparam int          aw         = $clog2(fifo_depth);
    localparam logic [aw:0] full_count = (aw + 1)'(fifo_depth);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_start = 2'd1;
    localparam logic [1:0] st_data  = 2'd2;
    localparam logic [1:0] st_stop  = 2'd3;

    logic [7:0]      mem_q [fifo_depth];
    logic [aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [aw:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     clkdiv_q, clkdiv_d;
    logic [1:0]      state_q, state_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     div_cnt_q, div_cnt_d;
    logic [15:0]     bit_div_q, bit_div_d;
    logic [7:0]      shift_q, shift_d;
    logic [xlen-1:0] r_data_q, r_data_d;

    logic [31:0]     offset;
    logic            sel_txdata, sel_status, sel_clkdiv;
    logic            fifo_full, fifo_empty, active;
    logic            push, push_ok, pop, bit_end;
    logic [xlen-1:0] status_word;
    logic            unused_value;

    assign offset     = io_control.addr - base_addr;
    assign sel_txdata = io_control.enable && (offset == 32'h0);
    assign sel_status = io_control.enable && (offset == 32'h4);
    assign sel_clkdiv = io_control.enable && (offset == 32'h8);

    assign fifo_full    = (count_q == full_count);
    assign fifo_empty   = (count_q == '0);
    assign active       = (state_q != st_idle);
    assign bit_end      = (div_cnt_q == bit_div_q);
    assign unused_value = ^io_control.value[31:16];

    assign status_word = {16'b0, 8'(count_q), 4'b0, overflow_q, active, fifo_empty, fifo_full};

    // Serializer; a frame latches its byte and bit time at the pop so CLKDIV writes only hit later frames.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        div_cnt_d = bit_end ? 16'd0 : div_cnt_q + 16'd1;
        pop       = 1'b0;
        case (state_q)
            st_idle: begin
                div_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = st_start;
                end
            end
            st_start: begin
                if (bit_end) begin
                    state_d = st_data;
                end
            end
            st_data: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = st_stop;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = st_start;
                    end else begin
                        state_d = st_idle;
                    end
                end
            end
        endcase
        if (pop) begin
            shift_d   = mem_q[rd_ptr_q];
            bit_div_d = clkdiv_q;
        end
    end

    // A push into a full FIFO still lands when the serializer frees a slot in the same cycle.
    always_comb begin
        push       = sel_txdata;
        push_ok    = push && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q + aw'(push_ok);
        rd_ptr_d   = rd_ptr_q + aw'(pop);
        count_d    = count_q + (aw + 1)'(push_ok) - (aw + 1)'(pop);
        overflow_d = overflow_q;
        if (sel_status && io_control.value[3]) begin
            overflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        clkdiv_d = clkdiv_q;
        if (sel_clkdiv) begin
            if (io_control.width == write_byte) begin
                clkdiv_d = {clkdiv_q[15:8], io_control.value[7:0]};
            end else begin
                clkdiv_d = io_control.value[15:0];
            end
        end
    end

    always_comb begin
        case (offset)
            32'h4:   r_data_d = status_word;
            32'h8:   r_data_d = {16'b0, clkdiv_q};
            default: r_data_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            clkdiv_q   <= reset_clkdiv;
            state_q    <= st_idle;
            bit_idx_q  <= 3'd0;
            div_cnt_q  <= 16'd0;
            bit_div_q  <= 16'd0;
            shift_q    <= 8'd0;
            r_data_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            clkdiv_q   <= clkdiv_d;
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            div_cnt_q  <= div_cnt_d;
            bit_div_q  <= bit_div_d;
            shift_q    <= shift_d;
            r_data_q   <= r_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= io_control.value[7:0];
        end
    end

    assign io_r_data = r_data_q;
    assign tx        = (state_q == st_start) ? 1'b0 :
                       (state_q == st_data)  ? shift_q[0] : 1'b1;
    assign tx_busy   = active || !fifo_empty;
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    localparam logic [31:0] base       = 32'h0003_0000;
    localparam logic [31:0] off_txdata = 32'h0;
    localparam logic [31:0] off_status = 32'h4;
    localparam logic [31:0] off_clkdiv = 32'h8;
    localparam logic [31:0] off_rsvd   = 32'hC;

    logic               clock;
    logic               reset;
    mem_write_control_t io_control;
    logic [31:0]        io_r_data;
    logic               tx;
    logic               tx_busy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mmio_uart_tx #(
        .base_addr   (base),
        .fifo_depth  (8),
        .reset_clkdiv(16'd433)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_control(io_control),
        .io_r_data (io_r_data),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } frame_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    frame_t      frame_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_track = 1'b0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Read monitor: one expected word per read issued, compared the cycle after the address edge.
    always @(posedge clock) rd_track <= rd_issue;

    always @(negedge clock) begin
        if (rd_track) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %h with no read outstanding", io_r_data);
            end else begin
                check(rd_name_q.pop_front(), io_r_data, rd_exp_q.pop_front());
            end
        end
    end

    // Serial monitor: every cycle of every bit of each expected frame must hold the expected level.
    task automatic check_frame(input frame_t f);
        for (int k = 0; k < 10; k++) begin
            logic exp_bit;
            logic act_bit;
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.data[k-1];
            act_bit = exp_bit;
            for (int c = 0; c <= f.div; c++) begin
                if (k != 0 || c != 0) @(negedge clock);
                if (tx !== exp_bit) act_bit = tx;
            end
            check($sformatf("frame_%02h_bit%0d", f.data, k), 32'(act_bit), 32'(exp_bit));
        end
    endtask

    initial begin : tx_monitor
        logic   prev;
        bit     more;
        frame_t f;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (mon_en && prev === 1'b1 && tx === 1'b0) begin
                if (frame_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected_start: got tx=0 at %0t, required idle high", $time);
                end else begin
                    more = 1'b1;
                    while (more) begin
                        f = frame_q.pop_front();
                        check_frame(f);
                        more = (frame_q.size() != 0) && frame_q[0].b2b;
                        if (more) @(negedge clock);
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d of %0d comparisons good", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [31:0] off, input logic en, input logic [31:0] val,
                         input mem_width_t w, input logic rd);
        io_control = '{addr: base + off, enable: en, value: val, width: w};
        rd_issue   = rd;
        @(negedge clock);
    endtask

    task automatic idle();
        drive(32'h100, 1'b0, 32'h0, write_word, 1'b0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] val, input mem_width_t w);
        drive(off, 1'b1, val, w, 1'b0);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(off, 1'b0, 32'h0, write_word, 1'b1);
    endtask

    task automatic wr_rd(input logic [31:0] off, input logic [31:0] val, input mem_width_t w,
                         input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(off, 1'b1, val, w, 1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b, input int div, input bit b2b);
        frame_t f;
        f.data = b;
        f.div  = div;
        f.b2b  = b2b;
        frame_q.push_back(f);
        wr(off_txdata, {24'hDEADBE, b}, write_word);
    endtask

    task automatic wait_drain(input int max, input string name);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < max) begin
            idle();
            n++;
        end
        check(name, 32'(tx_busy), 32'd0);
    endtask

    initial begin : stimulus
        io_control = '{addr: base + 32'h100, enable: 1'b0, value: 32'h0, width: write_word};
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_rdata", io_r_data, 32'd0);
        reset = 1'b1;
        idle();

        // Start a long frame at the reset divider, then reset in the middle of its start bit.
        wr(off_txdata, 32'h55, write_word);
        repeat (20) idle();
        check("midframe_tx_low", 32'(tx), 32'd0);
        check("midframe_busy", 32'(tx_busy), 32'd1);
        reset = 1'b0;
        idle();
        check("reset_midframe_tx", 32'(tx), 32'd1);
        check("reset_midframe_busy", 32'(tx_busy), 32'd0);
        idle();
        check("reset_midframe_rdata", io_r_data, 32'd0);
        reset = 1'b1;
        idle();
        mon_en = 1'b1;
        rd(off_status, 32'h0000_0002, "status_after_reset");
        rd(off_clkdiv, 32'd433, "clkdiv_after_reset");
        rd(off_txdata, 32'h0, "txdata_reads_zero");

        // Single frame, 4 cycles per bit.
        wr(off_clkdiv, 32'd3, write_word);
        push_byte(8'hA5, 3, 1'b0);
        check("push_tx_still_high", 32'(tx), 32'd1);
        check("push_busy_rises", 32'(tx_busy), 32'd1);
        idle();
        check("tx_low_after_pop", 32'(tx), 32'd0);
        repeat (39) idle();
        check("busy_in_last_stop_cycle", 32'(tx_busy), 32'd1);
        idle();
        check("busy_falls_after_stop", 32'(tx_busy), 32'd0);

        // Back-to-back frames at one cycle per bit.
        wr(off_clkdiv, 32'd0, write_word);
        push_byte(8'h01, 0, 1'b0);
        push_byte(8'h02, 0, 1'b1);
        push_byte(8'h03, 0, 1'b1);
        wait_drain(60, "drain_b2b");
        rd(off_status, 32'h0000_0002, "status_after_b2b");

        // Fill past capacity: first byte pops, eight fill the FIFO, the tenth is dropped.
        wr(off_clkdiv, 32'd100, write_word);
        push_byte(8'h10, 100, 1'b0);
        for (int i = 1; i <= 8; i++) push_byte(8'h10 + 8'(i), 100, 1'b1);
        wr(off_txdata, 32'h19, write_word);
        rd(off_status, 32'h0000_080D, "status_full_overflow");
        wr(off_status, 32'h8, write_word);
        rd(off_status, 32'h0000_0805, "status_overflow_cleared");
        wait_drain(10000, "drain_overflow");
        rd(off_status, 32'h0000_0002, "status_after_overflow_drain");

        // CLKDIV partial writes.
        wr(off_clkdiv, 32'h0000_1234, write_word);
        wr(off_clkdiv, 32'hAAAA_55FF, write_byte);
        rd(off_clkdiv, 32'h0000_12FF, "clkdiv_byte_write");
        wr(off_clkdiv, 32'h1111_BEEF, write_halfword);
        rd(off_clkdiv, 32'h0000_BEEF, "clkdiv_halfword_write");

        // Reserved and out-of-window accesses.
        rd(32'h10, 32'h0, "rd_above_window");
        rd(off_rsvd, 32'h0, "rd_reserved");
        rd(32'hFFFF_FFFC, 32'h0, "rd_below_window");
        wr(off_rsvd, 32'hFFFF_FFFF, write_word);
        wr(32'h10, 32'h0000_0042, write_word);
        wr(32'h14, 32'h0000_0008, write_word);
        wr(32'h18, 32'h0000_0007, write_word);
        check("no_push_outside_window", 32'(tx_busy), 32'd0);
        rd(off_clkdiv, 32'h0000_BEEF, "clkdiv_unchanged");
        rd(off_status, 32'h0000_0002, "status_unchanged");

        // A read sees state before a write to the same address in the same cycle.
        wr_rd(off_clkdiv, 32'h0000_0055, write_word, 32'h0000_BEEF, "rd_excludes_same_edge_write");
        rd(off_clkdiv, 32'h0000_0055, "clkdiv_after_write");
        repeat (3) idle();

        check("frames_outstanding", frame_q.size(), 32'd0);
        check("reads_outstanding", rd_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
